dec2ex_ctrl: RTL and testbench

Control end of the decode-to-execute pipeline register. It generates the six register-group enables, clk1_en to clk6_en, that the dec2ex register consumes. It sequences multi-cycle multiply/divide operations with an iteration counter and arbitrates decode stalls, traps, MMU stalls and flushes. It sits between the hazard unit / MMU / trap logic and the dec2ex register, and tells the execute stage when a mul/div result is final.

---
 rtl/dec2ex_ctrl.sv | 138 +++++++++++++
 tb/tb_dec2ex_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dec2ex_ctrl.sv
// dec2ex_ctrl: enables, mul/div sequencing and stall arbitration for dec2ex.
// Ports: clk, a_reset (async, active-high); hz_stall, stall_mmu, trap, flush,
//   dec_muldiv, dec_is_div, rs2_zero in; clk1_en..clk6_en, dec_stall,
//   md_busy, md_last, md_iter[CW-1:0], ex_bubble out.
//   Optional: define DEC2EX_DIVZERO_EARLY_EN to finish a divide by zero
//   in a single iteration.
module dec2ex_ctrl #(
  parameter int MUL_CYC = 4,
  parameter int DIV_CYC = 33,
  parameter int CW      = 6
) (
  input  logic          clk,
  input  logic          a_reset,
  input  logic          hz_stall,
  input  logic          stall_mmu,
  input  logic          trap,
  input  logic          flush,
  input  logic          dec_muldiv,
  input  logic          dec_is_div,
  input  logic          rs2_zero,
  output logic          clk1_en,
  output logic          clk2_en,
  output logic          clk3_en,
  output logic          clk4_en,
  output logic          clk5_en,
  output logic          clk6_en,
  output logic          dec_stall,
  output logic          md_busy,
  output logic          md_last,
  output logic [CW-1:0] md_iter,
  output logic          ex_bubble
);

  typedef enum logic [1:0] {
    IDLE,
    MD_RUN,
    TRAP_HOLD
  } state_t;

  localparam logic [CW-1:0] MUL_LIM = CW'(MUL_CYC - 1);
  localparam logic [CW-1:0] DIV_LIM = CW'(DIV_CYC - 1);

  state_t        state;
  logic [CW-1:0] limit;
  logic [CW-1:0] div_lim;
  logic          trap_hold;
  logic          at_lim;
  logic          run;
  logic          md_start;
  logic          bub_nxt;

`ifdef DEC2EX_DIVZERO_EARLY_EN
  // Zero divisor: quotient is all-ones, no iterations needed.
  assign div_lim = rs2_zero ? '0 : DIV_LIM;
`else
  logic unused_rs2;
  assign unused_rs2 = rs2_zero;
  assign div_lim    = DIV_LIM;
`endif

  assign run       = !a_reset;
  assign md_busy   = (state == MD_RUN);
  assign trap_hold = (state == TRAP_HOLD);
  assign at_lim    = (md_iter == limit);

  // Reset folds into dec_stall so every enable is held low in reset.
  assign dec_stall = a_reset | hz_stall | md_busy | trap_hold;

  assign clk1_en = run & !dec_stall;
  assign clk2_en = run & (!dec_stall | md_busy);
  assign clk3_en = run & (md_busy |
                   ((state == IDLE) & dec_muldiv & !dec_stall));
  assign clk4_en = run & (!dec_stall | trap);
  assign clk5_en = run & !md_busy;
  assign clk6_en = run & (!dec_stall | stall_mmu);

  // A trapped sequence is aborted, so it never reports a final result.
  assign md_last = md_busy & at_lim & !stall_mmu & !trap;

  assign md_start = (state == IDLE) & dec_muldiv &
                    !hz_stall & !flush & !trap;

  // Flush during MD_RUN targets a younger instruction; ignore it.
  always_comb begin
    bub_nxt = ex_bubble;
    if (trap | (flush & !md_busy)) begin
      bub_nxt = 1'b1;
    end else if (hz_stall & !md_busy) begin
      bub_nxt = 1'b1;
    end else if (clk1_en) begin
      bub_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge a_reset) begin
    if (a_reset) begin
      state     <= IDLE;
      md_iter   <= '0;
      limit     <= '0;
      ex_bubble <= 1'b1;
    end else begin
      ex_bubble <= bub_nxt;
      if (trap) begin
        state   <= TRAP_HOLD;
        md_iter <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (md_start) begin
              state   <= MD_RUN;
              md_iter <= '0;
              limit   <= dec_is_div ? div_lim : MUL_LIM;
            end
          end
          MD_RUN: begin
            if (!stall_mmu) begin
              if (at_lim) begin
                state   <= IDLE;
                md_iter <= '0;
              end else begin
                md_iter <= md_iter + 1'b1;
              end
            end
          end
          TRAP_HOLD: begin
            state   <= IDLE;
            md_iter <= '0;
          end
          default: begin
            state   <= IDLE;
            md_iter <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dec2ex_ctrl.sv
// tb_dec2ex_ctrl: directed vector table plus mul/div corner sequences.
// Second instance uses MUL_CYC=2 to cover the shortest legal sequence.
module tb_dec2ex_ctrl;

  logic clk = 1'b0;
  logic a_reset;
  logic hz_stall, stall_mmu, trap, flush;
  logic dec_muldiv, dec_is_div, rs2_zero;
  logic c1, c2, c3, c4, c5, c6;
  logic dec_stall, md_busy, md_last, ex_bubble;
  logic [5:0] md_iter;
  logic d1, d2, d3, d4, d5, d6;
  logic b_stall, b_busy, b_last, b_bubble;
  logic [5:0] b_iter;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dec2ex_ctrl dut (
    .clk(clk), .a_reset(a_reset),
    .hz_stall(hz_stall), .stall_mmu(stall_mmu),
    .trap(trap), .flush(flush),
    .dec_muldiv(dec_muldiv), .dec_is_div(dec_is_div),
    .rs2_zero(rs2_zero),
    .clk1_en(c1), .clk2_en(c2), .clk3_en(c3),
    .clk4_en(c4), .clk5_en(c5), .clk6_en(c6),
    .dec_stall(dec_stall), .md_busy(md_busy),
    .md_last(md_last), .md_iter(md_iter),
    .ex_bubble(ex_bubble)
  );

  dec2ex_ctrl #(.MUL_CYC(2), .DIV_CYC(3), .CW(6)) dut2 (
    .clk(clk), .a_reset(a_reset),
    .hz_stall(hz_stall), .stall_mmu(stall_mmu),
    .trap(trap), .flush(flush),
    .dec_muldiv(dec_muldiv), .dec_is_div(dec_is_div),
    .rs2_zero(rs2_zero),
    .clk1_en(d1), .clk2_en(d2), .clk3_en(d3),
    .clk4_en(d4), .clk5_en(d5), .clk6_en(d6),
    .dec_stall(b_stall), .md_busy(b_busy),
    .md_last(b_last), .md_iter(b_iter),
    .ex_bubble(b_bubble)
  );

  typedef struct {
    logic       hz;
    logic       mmu;
    logic       trp;
    logic       fl;
    logic       md;
    logic [5:0] en;
    logic       stall;
    logic       bub;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [5:0] ens();
    return {c6, c5, c4, c3, c2, c1};
  endfunction

  int exp_i;
  int cyc;
  int st;
  logic seen;
  int zlen;

  initial begin
`ifdef DEC2EX_DIVZERO_EARLY_EN
    zlen = 1;
`else
    zlen = 33;
`endif
    //         hz mmu trp fl md  {c6..c1}     stall bub
    tbl[0]  = '{0, 0, 0, 0, 0, 6'b111011, 0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0, 6'b111011, 0, 0};
    tbl[2]  = '{1, 1, 0, 0, 0, 6'b110000, 1, 0};
    tbl[3]  = '{1, 1, 0, 0, 0, 6'b110000, 1, 1};
    tbl[4]  = '{0, 0, 0, 1, 0, 6'b111011, 0, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 6'b111011, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 6'b111011, 0, 0};
    tbl[7]  = '{0, 0, 1, 0, 0, 6'b111011, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 6'b010000, 1, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 6'b111011, 0, 1};
    tbl[10] = '{1, 0, 0, 0, 1, 6'b010000, 1, 0};
    tbl[11] = '{0, 0, 0, 1, 1, 6'b111111, 0, 1};
    tbl[12] = '{0, 0, 1, 1, 1, 6'b111111, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 6'b010000, 1, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 6'b111011, 0, 1};

    a_reset = 1'b1;
    hz_stall = 0; stall_mmu = 0; trap = 0; flush = 0;
    dec_muldiv = 0; dec_is_div = 0; rs2_zero = 0;
    #2;
    chk("reset", {ens(), dec_stall, md_busy, md_last, md_iter, ex_bubble},
        {6'b000000, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1});
    @(negedge clk);
    a_reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      hz_stall = tbl[i].hz;
      stall_mmu = tbl[i].mmu;
      trap = tbl[i].trp;
      flush = tbl[i].fl;
      dec_muldiv = tbl[i].md;
      #2;
      chk($sformatf("vec%0d", i),
          {ens(), dec_stall, md_busy, md_last, md_iter, ex_bubble},
          {tbl[i].en, tbl[i].stall, 1'b0, 1'b0, 6'd0, tbl[i].bub});
      @(negedge clk);
    end
    hz_stall = 0; stall_mmu = 0; trap = 0; flush = 0; dec_muldiv = 0;

    // multiply, MUL_CYC=4 (dut2: MUL_CYC=2)
    dec_muldiv = 1; dec_is_div = 0;
    #2;
    chk("mul_issue_c1c3", {c1, c3}, 2'b11);
    @(negedge clk);
    dec_muldiv = 0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("mul_k%0d", k),
          {md_busy, md_iter, md_last, c1, c3, dec_stall},
          {1'b1, 6'(k), (k == 3), 1'b0, 1'b1, 1'b1});
      chk($sformatf("mul2_k%0d", k), {b_busy, b_last},
          {(k < 2), (k == 1)});
      @(negedge clk);
    end
    #2;
    chk("mul_after", {md_busy, c1, md_last}, 3'b010);
    @(negedge clk);

    // divide with a 3-cycle MMU stall at iteration 10
    dec_muldiv = 1; dec_is_div = 1;
    @(negedge clk);
    dec_muldiv = 0;
    exp_i = 0; cyc = 0; st = 0; seen = 0;
    for (int c = 0; c < 100; c++) begin
      stall_mmu = (exp_i == 10 && st < 3);
      #2;
      chk("div_iter", md_iter, exp_i);
      chk("div_last", md_last, (exp_i == 32 && !stall_mmu));
      cyc++;
      if (md_last) begin
        seen = 1;
        @(negedge clk);
        break;
      end
      if (stall_mmu) st++;
      else exp_i++;
      @(negedge clk);
    end
    stall_mmu = 0;
    chk("div_len", cyc, 36);
    chk("div_seen", seen, 1);
    #2;
    chk("div_done", {md_busy, c1}, 2'b01);
    @(negedge clk);

    // trap at iteration 5 of a divide
    dec_muldiv = 1; dec_is_div = 1;
    @(negedge clk);
    dec_muldiv = 0;
    repeat (5) @(negedge clk);
    #2;
    chk("trap_pre_iter", md_iter, 5);
    trap = 1;
    #1;
    chk("trap_cycle", {c4, md_last, c1}, 3'b100);
    @(negedge clk);
    trap = 0;
    #2;
    chk("trap_hold", {md_busy, dec_stall, ex_bubble, md_last, md_iter},
        {1'b0, 1'b1, 1'b1, 1'b0, 6'd0});
    @(negedge clk);
    #2;
    chk("trap_exit", {dec_stall, md_busy, md_last}, 3'b000);
    @(negedge clk);

    // divide by zero
    dec_muldiv = 1; dec_is_div = 1; rs2_zero = 1;
    @(negedge clk);
    dec_muldiv = 0; rs2_zero = 0;
    cyc = 0; seen = 0;
    for (int c = 0; c < 100; c++) begin
      #2;
      cyc++;
      if (md_last) begin
        seen = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    chk("divz_len", cyc, zlen);
    chk("divz_seen", seen, 1);
    #2;
    chk("divz_done", md_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
